// File: rtl/sample_server.sv
// -----------------------------------------------------------------------------
// sample_server
//
// Producer-side FIFO feeding a registered single-word offer stage that hands
// samples to a consumer (filter) through a req/ack handshake.
//
// A transfer happens on any rising edge where req and ack are both high. Once
// a sample is offered (ack=1) it stays on data until the consumer takes it; an
// offer is never withdrawn. After a transfer, the next FIFO head is loaded into
// the offer stage on the same edge, so a consumer holding req high receives one
// sample per cycle.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous, active-high reset
//   wr_en         producer write strobe
//   wr_data       producer sample
//   full          FIFO holds DEPTH words (the offered word is not counted)
//   count         FIFO occupancy 0..DEPTH (the offered word is not counted)
//   req           consumer read request
//   ack           a valid sample is being offered on data
//   data          offered sample, registered
//   overflow      sticky flag: a write was attempted while full
//   underrun_cnt  saturating count of cycles where req found nothing to offer
// -----------------------------------------------------------------------------
module sample_server #(
  parameter int DWIDTH    = 16,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [0:DWIDTH-1] wr_data,
  output logic              full,
  output logic [0:DEPTH_LOG] count,
  input  logic              req,
  output logic              ack,
  output logic [0:DWIDTH-1] data,
  output logic              overflow,
  output logic [0:15]       underrun_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_LAST = DEPTH_LOG'(DEPTH - 1);
  localparam logic [DEPTH_LOG:0]   CNT_ONE  = (DEPTH_LOG + 1)'(1);
  localparam logic [DEPTH_LOG:0]   CNT_FULL = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [15:0]          UND_MAX  = 16'hFFFF;
  localparam logic [15:0]          UND_ONE  = 16'd1;

  // Pointer increment with explicit wrap so a non-power-of-two DEPTH still
  // cycles through exactly DEPTH slots.
  function automatic logic [DEPTH_LOG-1:0] ptr_inc(input logic [DEPTH_LOG-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_q,    state_d;
  logic [DWIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q,   wr_ptr_d;
  logic [DEPTH_LOG-1:0] rd_ptr_q,   rd_ptr_d;
  logic [DEPTH_LOG:0]   count_q,    count_d;
  logic [DWIDTH-1:0]    data_q,     data_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          underrun_q, underrun_d;

  // ---------------------------------------------------------------------------
  // Handshake decodes (all from registered state plus the current inputs)
  // ---------------------------------------------------------------------------
  logic empty;
  logic full_int;
  logic offering;
  logic transfer;
  logic push;
  logic pop;

  assign empty    = (count_q == '0);
  assign full_int = (count_q == CNT_FULL);
  assign offering = (state_q == OFFER);
  assign transfer = req && offering;

  // A pop feeds the offer stage. In IDLE, req with data waiting fetches the
  // head; in OFFER, req is itself the transfer, which frees the stage for the
  // next head. Both reduce to req with a non-empty FIFO.
  assign pop  = req && !empty;

  // full is the registered occupancy, so a write in the same cycle as a pop
  // from a full FIFO is still dropped.
  assign push = wr_en && !full_int;

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req && !empty)    state_d = OFFER;
      OFFER: if (transfer && empty) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so that every
  // flop samples the pre-edge value of every other flop, independent of the
  // order in which the simulator runs the blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    underrun_d = underrun_q;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);

    // The offered word only changes on a pop; after the last transfer it keeps
    // its value while ack drops.
    if (pop) begin
      data_d   = mem_q[rd_ptr_q];
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (wr_en && full_int) overflow_d = 1'b1;

    // Starved request: consumer asks while nothing is offered and nothing is
    // stored. A word written this same cycle does not count as available.
    if (!offering && req && empty && (underrun_q != UND_MAX))
      underrun_d = underrun_q + UND_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      underrun_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: the storage array has no reset. Reset clears the pointers and count,
  // which makes every slot unreachable until it is rewritten, so resetting the
  // array would only cost flops and block RAM inference.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Outputs (pure registered-state decodes)
  // ---------------------------------------------------------------------------
  assign full         = full_int;
  assign count        = count_q;
  assign ack          = offering;
  assign data         = data_q;
  assign overflow     = overflow_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_sample_server.sv
// -----------------------------------------------------------------------------
// tb_sample_server
//
// Directed bench for sample_server with default parameters (DWIDTH=16,
// DEPTH=16). Inputs are driven 1 ns after each rising edge and outputs are
// sampled at the same point, so every check sees the registered result of the
// edge just taken. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sample_server;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [0:15] wr_data;
  logic        full;
  logic [0:4]  count;
  logic        req;
  logic        ack;
  logic [0:15] data;
  logic        overflow;
  logic [0:15] underrun_cnt;

  int n_vec;
  int n_err;

  sample_server #(
    .DWIDTH   (16),
    .DEPTH    (16),
    .DEPTH_LOG(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .count        (count),
    .req          (req),
    .ack          (ack),
    .data         (data),
    .overflow     (overflow),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
  endtask

  // Reset asserted mid-cycle, held across two edges, released after a
  // falling edge, and the bench resynchronised to 1 ns after a rising edge.
  task automatic reset_release();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    req     = 1'b0;

    // ---------------- reset state ----------------
    #1 rst = 1'b1;
    #1;
    check("rst_ack",      ack,          0);
    check("rst_data",     data,         0);
    check("rst_count",    count,        0);
    check("rst_full",     full,         0);
    check("rst_overflow", overflow,     0);
    check("rst_underrun", underrun_cnt, 0);
    reset_release();
    check("post_rst_ack", ack, 0);

    // ---------------- three words, req held ----------------
    write_word(16'h0001);
    write_word(16'h0002);
    write_word(16'h0003);
    check("b2b_count_loaded", count, 3);
    req = 1'b1;
    #1;
    check("b2b_ack_not_comb", ack, 0);
    tick();
    check("b2b_ack1",  ack,   1);
    check("b2b_data1", data,  16'h0001);
    check("b2b_cnt1",  count, 2);
    tick();
    check("b2b_data2", data,  16'h0002);
    check("b2b_cnt2",  count, 1);
    tick();
    check("b2b_ack3",  ack,   1);
    check("b2b_data3", data,  16'h0003);
    check("b2b_cnt3",  count, 0);
    tick();
    req = 1'b0;
    check("b2b_ack_end",   ack,          0);
    check("b2b_data_hold", data,         16'h0003);
    check("b2b_count_end", count,        0);
    check("b2b_no_under",  underrun_cnt, 0);

    // ---------------- offer held while req low ----------------
    write_word(16'h00AA);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("hold_ack_start",  ack,  1);
    check("hold_data_start", data, 16'h00AA);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_ack_c%0d", i),  ack,  1);
      check($sformatf("hold_data_c%0d", i), data, 16'h00AA);
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    check("hold_taken_ack", ack, 0);

    // ---------------- starved requests ----------------
    req = 1'b1;
    repeat (3) tick();
    check("under_3", underrun_cnt, 3);
    check("under_3_ack", ack, 0);
    wr_en   = 1'b1;
    wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    check("under_wr_cycle", underrun_cnt, 4);
    check("under_no_bypass", ack, 0);
    check("under_count1", count, 1);
    tick();
    check("under_ack",  ack,          1);
    check("under_data", data,         16'h1234);
    check("under_hold", underrun_cnt, 4);
    tick();
    req = 1'b0;
    check("under_done_ack", ack,          0);
    check("under_done_cnt", underrun_cnt, 4);

    // ---------------- fill past full ----------------
    for (int i = 1; i <= 17; i++) begin
      write_word(16'(i));
      if (i == 16) begin
        check("fill16_full",  full,     1);
        check("fill16_count", count,    16);
        check("fill16_ovf",   overflow, 0);
      end
    end
    check("fill17_full",  full,     1);
    check("fill17_count", count,    16);
    check("fill17_ovf",   overflow, 1);
    req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("drain_data_%0d", i), data,  32'(i + 1));
      check($sformatf("drain_cnt_%0d", i),  count, 32'(15 - i));
    end
    tick();
    req = 1'b0;
    check("drain_ack_end", ack, 0);

    // ---------------- write + transfer while full ----------------
    #2 rst = 1'b1;
    #1;
    check("rst2_ovf", overflow, 0);
    reset_release();
    for (int i = 0; i < 16; i++) write_word(16'h0100 + 16'(i));
    req = 1'b1;
    tick();
    req = 1'b0;
    check("wf_first_data", data,  16'h0100);
    check("wf_first_cnt",  count, 15);
    write_word(16'h0200);
    check("wf_refill_full", full,     1);
    check("wf_refill_ovf",  overflow, 0);
    req     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 16'h0300;
    tick();
    wr_en = 1'b0;
    check("wf_both_data", data,     16'h0101);
    check("wf_both_cnt",  count,    15);
    check("wf_both_ovf",  overflow, 1);
    check("wf_both_ack",  ack,      1);
    for (int k = 0; k < 14; k++) begin
      tick();
      check($sformatf("wf_drain_%0d", k), data, 32'h0102 + 32'(k));
    end
    tick();
    check("wf_wrap_word", data,  16'h0200);
    check("wf_wrap_cnt",  count, 0);
    tick();
    req = 1'b0;
    check("wf_dropped_ack", ack, 0);

    // ---------------- async reset mid-offer ----------------
    req = 1'b1;
    tick();
    req = 1'b0;
    check("ar_under_pre", underrun_cnt, 1);
    for (int i = 0; i < 6; i++) write_word(16'h0050 + 16'(i));
    req = 1'b1;
    tick();
    req = 1'b0;
    check("ar_pre_ack",   ack,   1);
    check("ar_pre_count", count, 5);
    #3 rst = 1'b1;
    #1;
    check("ar_ack",      ack,          0);
    check("ar_data",     data,         0);
    check("ar_count",    count,        0);
    check("ar_full",     full,         0);
    check("ar_overflow", overflow,     0);
    check("ar_underrun", underrun_cnt, 0);
    reset_release();
    check("ar_release_ack", ack, 0);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("ar_after_ack",   ack,          0);
    check("ar_after_count", count,        0);
    check("ar_after_under", underrun_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
